// File: rtl/bcd_down_counter.sv
// Multi-digit packed-BCD countdown timer with a prescaled tick, terminal-zero flag
// and optional reload of the last preset. Single clock domain.
module bcd_down_counter #(
  parameter int DIGITS      = 2,
  parameter int PRESCALE    = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                enable,
  output logic [4*DIGITS-1:0] count,
  output logic                zero,
  output logic                running,
  output logic                done
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_next_state;
  logic [CW-1:0]   r_count, w_next_count;
  logic [CW-1:0]   r_preset, w_next_preset;
  logic [PW-1:0]   r_presc, w_next_presc;
  logic            r_done, w_next_done;
  logic            w_tick;
  logic            w_zero;
  logic            w_reload_ok;
  logic [CW-1:0]   w_dec;
  logic [CW-1:0]   w_sat;

  // Clamp each preset digit into 0..9 so the count never holds a non-BCD digit.
  function automatic logic [CW-1:0] bcd_sat(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_zero      = (r_count == '0);
  assign w_reload_ok = (AUTO_RELOAD != 0) && (r_preset != '0);
  assign w_dec       = bcd_dec(r_count);
  assign w_sat       = bcd_sat(load_val);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    w_next_state  = r_state;
    w_next_count  = r_count;
    w_next_preset = r_preset;
    w_next_presc  = r_presc;
    w_next_done   = 1'b0;
    w_tick        = 1'b0;

    if (load) begin
      w_next_count  = w_sat;
      w_next_preset = w_sat;
      w_next_presc  = '0;
      w_next_state  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !w_zero) begin
            w_next_state = S_RUN;
            w_next_presc = '0;
          end
        end
        S_RUN: begin
          if (enable) begin
            if (r_presc == PMAX) begin
              w_next_presc = '0;
              w_tick       = 1'b1;
            end else begin
              w_next_presc = r_presc + 1'b1;
            end
          end
          if (w_tick) begin
            if (w_zero) begin
              // Only reachable with reload active: restart from the preset, never wrap to all-9s.
              if (w_reload_ok) w_next_count = r_preset;
              else             w_next_state = S_DONE;
            end else begin
              w_next_count = w_dec;
              if (w_dec == '0) begin
                w_next_done = 1'b1;
                if (!w_reload_ok) w_next_state = S_DONE;
              end
            end
          end
        end
        S_DONE:  w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_preset <= '0;
      r_presc  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_count  <= w_next_count;
      r_preset <= w_next_preset;
      r_presc  <= w_next_presc;
      r_done   <= w_next_done;
    end
  end

  assign count   = r_count;
  assign zero    = w_zero;
  assign running = (r_state == S_RUN);
  assign done    = r_done;

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
Synchronous multi-digit BCD down-counter (countdown timer). It is the decrementing counterpart of the team's mod-10 ripple up-counter. It is loaded with a BCD preset, counts down one step per prescaled tick, and flags terminal zero. All flops are on a single clock, with no ripple clocks. It feeds display/timer logic that consumes packed BCD digits.

Parameters:
DIGITS, 2, number of BCD digits (1..8); count width = 4*DIGITS.
PRESCALE, 4, clk cycles per decrement tick (>=1); prescaler width = clog2(PRESCALE), minimum 1.
AUTO_RELOAD, 0, 0 = stop at zero; 1 = reload the last preset on reaching zero and keep running.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
load  input  1  load strobe, sampled on rising clk.
load_val  input  4*DIGITS  packed BCD preset; digit 0 is in bits [3:0].
start  input  1  start request.
enable  input  1  run qualifier; low = pause.
count  output  4*DIGITS  current packed BCD value.
zero  output  1  combinational: count == 0.
running  output  1  high while state is RUN.
done  output  1  one-cycle pulse when count reaches zero from RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, preset register=0, prescaler=0, state=IDLE, done=0.
  - zero=1, running=0.
  - Release is synchronous to the next clk edge.
- States: IDLE, RUN, DONE.
- Priority each cycle: load > start > tick.
- load=1 (any state):
  - count and preset register take load_val.
  - Any digit >9 saturates to 9 (e.g. 4'hC -> 9).
  - prescaler=0, state=IDLE, done=0.
  - A start in the same cycle is ignored.
- IDLE:
  - start=1 with count!=0 -> RUN, prescaler=0.
  - start=1 with count==0 -> ignored, stay IDLE.
- RUN, enable=0: prescaler and count hold; running stays 1.
- RUN, enable=1:
  - Prescaler increments.
  - At PRESCALE-1 it wraps to 0 and issues a tick in the same cycle.
  - PRESCALE=1 gives a tick every cycle.
- Tick (BCD decrement):
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - Digits only ever hold 0..9.
  - Latency: count updates on the clk edge at which the tick occurs.
- Tick that makes count 0:
  - done=1 for exactly one cycle, on the cycle after the edge at which count becomes 0.
  - AUTO_RELOAD=0: state -> DONE for one cycle, then IDLE; count stays 0.
  - AUTO_RELOAD=1: on the following tick, count reloads the preset register instead of wrapping to all-9s; state stays RUN. done still pulses at each zero.
  - AUTO_RELOAD=1 with preset 0: no reload; behaves as AUTO_RELOAD=0.
- start while in RUN or DONE: ignored.
- zero is combinational from count, valid in every state.
- Reset mid-RUN: immediate return to reset values; no done pulse.
- No wrap from 0 to all-9s ever occurs.

Test Plan:
1. Reset then release: count=0x00, zero=1, running=0, done=0. Pulse start -> stays IDLE, running=0.
2. load_val=0x12, load; start; enable=1 (DIGITS=2, PRESCALE=4).
   - count sequence 12,11,10,09,08 ... 01,00, one step every 4 clk.
   - 10->09 borrow is correct.
   - done pulses once after 00; running drops within 2 cycles.
3. load_val=0x1F -> count=0x19. Start, then hold enable=0 for 10 cycles mid-count: count and prescaler frozen. Re-assert enable: resumes with the remaining prescale phase.
4. AUTO_RELOAD=1, preset 0x03, enable=1:
   - count sequence 03,02,01,00,03,02 ...
   - done pulses at each 00; running stays 1.
5. load and start asserted together during RUN with load_val=0x50: count=0x50, state IDLE, running=0, prescaler=0.
6. Drive reset low asynchronously between clk edges mid-RUN: outputs return to reset values before the next edge; no done pulse.
